cpu_debug_ocimem_arbiter: RTL and testbench

Shares the single-port on-chip debug memory (OCI RAM) between two requesters: the JTAG debug slave's system-clock command pulses and the CPU's Avalon-MM debug-memory slave port. The block decodes JTAG ocimem commands, sequences RAM reads and writes, auto-increments the JTAG address and returns read data on MonDReg with monitor_ready/monitor_error. It sits between the debug slave wrapper outputs and the OCI RAM, in the clk domain.

---
 rtl/cpu_debug_ocimem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_cpu_debug_ocimem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_ocimem_arbiter.sv
// Arbitrates the single-port OCI debug RAM between JTAG ocimem commands and the CPU Avalon-MM port.
// Optional macro OCIMEM_WRITE_PROTECT_EN adds cpu_debugaccess; CPU writes without it leave the RAM untouched.
module cpu_debug_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
`ifdef OCIMEM_WRITE_PROTECT_EN
    input  logic              cpu_debugaccess,
`endif
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDATA} state_t;
    typedef enum logic [1:0] {CMD_A, CMD_B, CMD_NA} cmd_t;

    state_t              r_state, w_next_state;
    cmd_t                r_cmd, w_accept_cmd;
    logic                r_grant_jtag, r_last_jtag, r_pending;
    logic [ADDR_W-1:0]   r_cmd_addr, r_jtag_addr, w_jaddr_next;
    logic [31:0]         r_cmd_wdata, r_mondreg;
    logic                r_ready, r_error;

    logic                w_any_pulse, w_multi_pulse, w_accept, w_drop;
    logic                w_jtag_req, w_cpu_req, w_cpu_wr_ok;
    logic                w_grant_take, w_grant_next, w_jtag_done, w_mon_load;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic                w_ram_wren, w_cpu_wait;
    logic [31:0]         w_ram_wdata, w_cpu_rdata;
    logic                w_unused_jdo;

`ifdef OCIMEM_WRITE_PROTECT_EN
    assign w_cpu_wr_ok = cpu_debugaccess;
`else
    assign w_cpu_wr_ok = 1'b1;
`endif

    assign w_unused_jdo  = &{jdo[37:35], jdo[2:0]};
    assign w_any_pulse   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_multi_pulse = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                         | (take_action_ocimem_b & take_no_action_ocimem_a);
    assign w_accept      = w_any_pulse & ~r_pending;
    assign w_drop        = r_pending ? w_any_pulse : w_multi_pulse;
    assign w_accept_cmd  = take_action_ocimem_a ? CMD_A : (take_action_ocimem_b ? CMD_B : CMD_NA);
    // A command accepted this cycle already requests, so ISSUE follows the pulse directly.
    assign w_jtag_req    = r_pending | w_accept;
    assign w_cpu_req     = cpu_read | cpu_write;

    always_comb begin
        w_next_state = r_state;
        w_grant_take = 1'b0;
        w_grant_next = r_grant_jtag;
        w_jaddr_next = r_jtag_addr;
        w_jtag_done  = 1'b0;
        w_mon_load   = 1'b0;
        w_ram_addr   = '0;
        w_ram_wren   = 1'b0;
        w_ram_wdata  = '0;
        w_cpu_wait   = 1'b1;
        w_cpu_rdata  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_jtag_req || w_cpu_req) begin
                    w_grant_take = 1'b1;
                    w_grant_next = (w_jtag_req && w_cpu_req) ? ~r_last_jtag : w_jtag_req;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_grant_jtag) begin
                    case (r_cmd)
                        CMD_A: begin
                            w_ram_addr   = r_cmd_addr;
                            w_jaddr_next = r_cmd_addr;
                            w_next_state = S_RDATA;
                        end
                        CMD_B: begin
                            w_ram_addr   = r_jtag_addr;
                            w_ram_wren   = 1'b1;
                            w_ram_wdata  = r_cmd_wdata;
                            w_jaddr_next = r_jtag_addr + ADDR_W'(1);
                            w_jtag_done  = 1'b1;
                            w_next_state = S_IDLE;
                        end
                        default: begin
                            w_ram_addr   = r_jtag_addr;
                            w_jaddr_next = r_jtag_addr + ADDR_W'(1);
                            w_next_state = S_RDATA;
                        end
                    endcase
                end else begin
                    w_ram_addr = cpu_address;
                    if (cpu_write) begin
                        w_ram_wren   = w_cpu_wr_ok;
                        w_ram_wdata  = cpu_writedata;
                        w_cpu_wait   = 1'b0;
                        w_next_state = S_IDLE;
                    end else if (cpu_read) begin
                        w_next_state = S_RDATA;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_RDATA: begin
                w_next_state = S_IDLE;
                if (r_grant_jtag) begin
                    w_mon_load  = 1'b1;
                    w_jtag_done = 1'b1;
                end else begin
                    w_ram_addr = cpu_address;
                    if (cpu_read) begin
                        w_cpu_rdata = ram_rdata;
                        w_cpu_wait  = 1'b0;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cmd        <= CMD_A;
            r_grant_jtag <= 1'b0;
            r_last_jtag  <= 1'b0;
            r_pending    <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_jtag_addr  <= '0;
            r_mondreg    <= '0;
            r_ready      <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_jtag_addr <= w_jaddr_next;
            if (w_grant_take) begin
                r_grant_jtag <= w_grant_next;
                r_last_jtag  <= w_grant_next;
            end
            if (w_accept) begin
                r_pending   <= 1'b1;
                r_cmd       <= w_accept_cmd;
                r_cmd_addr  <= jdo[17+ADDR_W-1:17];
                r_cmd_wdata <= jdo[34:3];
                r_ready     <= 1'b0;
            end else if (w_jtag_done) begin
                r_pending <= 1'b0;
                r_ready   <= 1'b1;
            end
            if (w_mon_load) begin
                r_mondreg <= ram_rdata;
            end
            // A drop in the same cycle as an accepted cmd a keeps the error visible.
            if (w_drop) begin
                r_error <= 1'b1;
            end else if (w_accept && w_accept_cmd == CMD_A) begin
                r_error <= 1'b0;
            end
        end
    end

    assign ram_addr        = w_ram_addr;
    assign ram_wdata       = w_ram_wdata;
    assign ram_wren        = w_ram_wren & ~reset;
    assign cpu_waitrequest = w_cpu_wait | reset;
    assign cpu_readdata    = reset ? '0 : w_cpu_rdata;
    assign MonDReg         = r_mondreg;
    assign monitor_ready   = r_ready;
    assign monitor_error   = r_error;

endmodule

// File: tb/tb_cpu_debug_ocimem_arbiter.sv
// Scoreboard bench for cpu_debug_ocimem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_cpu_debug_ocimem_arbiter;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
`ifdef OCIMEM_WRITE_PROTECT_EN
    logic              cpu_debugaccess;
`endif
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read, cpu_write;
    logic [31:0]       cpu_writedata, cpu_readdata;
    logic              cpu_waitrequest;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [31:0]       ram_wdata, ram_rdata;
    logic [31:0]       MonDReg;
    logic              monitor_ready, monitor_error;

    always #5 clk = ~clk;

    cpu_debug_ocimem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .reset(reset),
        .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
`ifdef OCIMEM_WRITE_PROTECT_EN
        .cpu_debugaccess(cpu_debugaccess),
`endif
        .cpu_address(cpu_address),
        .cpu_read(cpu_read),
        .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata),
        .cpu_readdata(cpu_readdata),
        .cpu_waitrequest(cpu_waitrequest),
        .ram_addr(ram_addr),
        .ram_wren(ram_wren),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .MonDReg(MonDReg),
        .monitor_ready(monitor_ready),
        .monitor_error(monitor_error)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem     [256];
    logic [31:0] exp_mem [256];
    logic [31:0] jtag_q [$];
    logic [31:0] cpu_q  [$];
    logic [7:0]  tb_jaddr;
    logic [31:0] exp_last;
    logic        load_mem;
    logic        prev_ready = 1'b0;

    function automatic logic [31:0] init_word(input int unsigned i);
        if (i == 16) return 32'hDEAD_BEEF;
        return 32'hA500_0000 + (i * 32'h0001_0101);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (load_mem) begin
            for (int unsigned i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    // Scoreboard: pop one entry per JTAG completion and per CPU read completion.
    always @(negedge clk) begin
        if (!reset) begin
            if (monitor_ready && !prev_ready) begin
                if (jtag_q.size() == 0) check_eq("jtag_unexpected_done", {31'b0, monitor_ready}, 32'd0);
                else check_eq("mondreg", MonDReg, jtag_q.pop_front());
            end
            if (!cpu_waitrequest && cpu_read && !cpu_write) begin
                if (cpu_q.size() == 0) check_eq("cpu_unexpected_done", {31'b0, cpu_waitrequest}, 32'd1);
                else check_eq("cpu_readdata", cpu_readdata, cpu_q.pop_front());
            end
        end
        prev_ready <= monitor_ready;
    end

    // kind: 0 = take_action_a, 1 = take_action_b, 2 = take_no_action_a
    task automatic jtag_cmd(input int kind, input logic [7:0] a, input logic [31:0] d, input bit accept);
        jdo = '0;
        case (kind)
            0: begin
                jdo[24:17] = a;
                if (accept) begin
                    tb_jaddr = a;
                    exp_last = exp_mem[a];
                    jtag_q.push_back(exp_last);
                end
                take_action_ocimem_a = 1'b1;
            end
            1: begin
                jdo[34:3] = d;
                if (accept) begin
                    exp_mem[tb_jaddr] = d;
                    tb_jaddr = tb_jaddr + 8'd1;
                    jtag_q.push_back(exp_last);
                end
                take_action_ocimem_b = 1'b1;
            end
            default: begin
                if (accept) begin
                    exp_last = exp_mem[tb_jaddr];
                    tb_jaddr = tb_jaddr + 8'd1;
                    jtag_q.push_back(exp_last);
                end
                take_no_action_ocimem_a = 1'b1;
            end
        endcase
        @(posedge clk); #1;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_jtag();
        int n = 0;
        while (jtag_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (jtag_q.size() != 0) begin
            check_eq("jtag_timeout", 32'(jtag_q.size()), 32'd0);
            jtag_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_cpu(input string tag, input int lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_waitrequest && n < 30);
        check_eq(tag, 32'(n), 32'(lat));
        @(posedge clk); #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [7:0] a);
        cpu_q.push_back(exp_mem[a]);
        cpu_address = a;
        cpu_read    = 1'b1;
        wait_cpu("cpu_rd_latency", 3);
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input bit performed);
        if (performed) exp_mem[a] = d;
        cpu_address   = a;
        cpu_writedata = d;
        cpu_write     = 1'b1;
        wait_cpu("cpu_wr_latency", 2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_wait"},   {31'b0, cpu_waitrequest}, 32'd1);
        check_eq({tag, "_wren"},   {31'b0, ram_wren},        32'd0);
        check_eq({tag, "_rdata"},  cpu_readdata,             32'd0);
        check_eq({tag, "_mon"},    MonDReg,                  32'd0);
        check_eq({tag, "_ready"},  {31'b0, monitor_ready},   32'd0);
        check_eq({tag, "_error"},  {31'b0, monitor_error},   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; load_mem = 1'b1; jdo = '0;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
        cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_writedata = '0;
`ifdef OCIMEM_WRITE_PROTECT_EN
        cpu_debugaccess = 1'b1;
`endif
        tb_jaddr = '0; exp_last = '0;
        for (int unsigned i = 0; i < 256; i++) exp_mem[i] = init_word(i);
        @(posedge clk); #1;
        load_mem = 1'b0;
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1;
        reset = 1'b0;

        // JTAG load/read with latency check: visible exactly at T+3.
        jtag_cmd(0, 8'h10, '0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_eq("lat_ready_t2", {31'b0, monitor_ready}, 32'd0);
        @(negedge clk);
        check_eq("lat_ready_t3", {31'b0, monitor_ready}, 32'd1);
        check_eq("lat_mon_t3", MonDReg, 32'hDEAD_BEEF);
        wait_jtag();
        jtag_cmd(2, '0, '0, 1'b1);   // re-reads 0x10: cmd a does not increment
        wait_jtag();
        jtag_cmd(2, '0, '0, 1'b1);   // 0x11
        wait_jtag();

        // CPU write then JTAG readback, CPU readback.
        cpu_wr(8'h30, 32'hCAFE_F00D, 1'b1);
        jtag_cmd(0, 8'h30, '0, 1'b1);
        wait_jtag();
        cpu_rd(8'h30);

        // Address wrap.
        jtag_cmd(0, 8'hFF, '0, 1'b1);
        wait_jtag();
        jtag_cmd(1, '0, 32'h1234_5678, 1'b1);
        wait_jtag();
        jtag_cmd(2, '0, '0, 1'b1);
        wait_jtag();
        cpu_rd(8'hFF);

        // Contention: last grant is CPU, so JTAG goes first.
        cpu_rd(8'h21);
        cpu_q.push_back(exp_mem[8'h20]);
        cpu_address = 8'h20;
        cpu_read    = 1'b1;
        jtag_cmd(0, 8'h60, '0, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_waitrequest && n < 20);
        check_eq("cont_cpu_cycles", 32'(n), 32'd5);
        check_eq("cont_jtag_first", {31'b0, monitor_ready}, 32'd1);
        @(posedge clk); #1;
        cpu_read = 1'b0;
        wait_jtag();

        // Overrun: dropped pulse sets sticky error; only cmd a clears it.
        jtag_cmd(2, '0, '0, 1'b1);
        jtag_cmd(2, '0, '0, 1'b0);
        wait_jtag();
        @(negedge clk);
        check_eq("ovr_error_set", {31'b0, monitor_error}, 32'd1);
        @(posedge clk); #1;
        jtag_cmd(2, '0, '0, 1'b1);
        wait_jtag();
        @(negedge clk);
        check_eq("ovr_error_sticky", {31'b0, monitor_error}, 32'd1);
        @(posedge clk); #1;
        jtag_cmd(0, 8'h50, '0, 1'b1);
        wait_jtag();
        @(negedge clk);
        check_eq("ovr_error_clear", {31'b0, monitor_error}, 32'd0);
        @(posedge clk); #1;

        // Reset mid-stream with a JTAG access in flight and a CPU read waiting.
        cpu_address = 8'h41;
        cpu_read    = 1'b1;
        jtag_cmd(0, 8'h40, '0, 1'b0);
        reset = 1'b1;
        jtag_q.delete(); cpu_q.delete();
        tb_jaddr = '0; exp_last = '0;
        @(negedge clk);
        check_eq("rst1_wait",  {31'b0, cpu_waitrequest}, 32'd1);
        check_eq("rst1_wren",  {31'b0, ram_wren},        32'd0);
        check_eq("rst1_rdata", cpu_readdata,             32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("rst2");
        @(posedge clk); #1;
        reset = 1'b0; cpu_read = 1'b0;
        jtag_cmd(2, '0, '0, 1'b1);   // jtag_addr restarts at 0
        wait_jtag();

        // Reset during ISSUE of a CPU write: the write must not land.
        cpu_address = 8'h05; cpu_writedata = 32'h55AA_55AA; cpu_write = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_issue_wren", {31'b0, ram_wren},        32'd0);
        check_eq("rst_issue_wait", {31'b0, cpu_waitrequest}, 32'd1);
        @(posedge clk); #1;
        cpu_write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        tb_jaddr = '0; exp_last = '0;
        cpu_rd(8'h05);

`ifdef OCIMEM_WRITE_PROTECT_EN
        cpu_debugaccess = 1'b0;
        cpu_wr(8'h06, 32'h0BAD_0BAD, 1'b0);
        cpu_debugaccess = 1'b1;
        cpu_rd(8'h06);
        jtag_cmd(0, 8'h07, '0, 1'b1);
        wait_jtag();
        jtag_cmd(1, '0, 32'h7777_0007, 1'b1);
        wait_jtag();
        cpu_rd(8'h07);
`endif

        check_eq("jtag_q_drained", 32'(jtag_q.size()), 32'd0);
        check_eq("cpu_q_drained",  32'(cpu_q.size()),  32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
